// File: rtl/coa_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module : coa_arith_pkg
// Brief  : Shared constants for the arithmetic datapaths (divider, Booth mult).
// Rev    : 1.0  initial release
// ============================================================================
package coa_arith_pkg;

    localparam int COA_WIDTH = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage : coa_arith_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring shift-subtract step on magnitudes.
// Rev    : 1.0  initial release
// ============================================================================
module div_step
    import coa_arith_pkg::*;
#(
    parameter int WIDTH = COA_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [2*WIDTH:0] w_sh;
    logic [WIDTH:0]   w_t;

    assign w_sh = {a, q} << 1;
    assign w_t  = w_sh[2*WIDTH:WIDTH] - {1'b0, m};

    // A borrow in the top bit means the trial subtraction went negative: restore.
    assign a_next = w_t[WIDTH] ? w_sh[2*WIDTH:WIDTH] : w_t;
    assign q_next = w_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~w_t[WIDTH]};

endmodule : div_step
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_restoring_divider
// Brief  : Sequential signed restoring divider, one step per clk_fast cycle.
// Rev    : 1.0  initial release
// ============================================================================
module seq_restoring_divider
    import coa_arith_pkg::*;
#(
    parameter int WIDTH = COA_WIDTH
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0] c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_sd;
    logic               r_sv;
    logic               r_ovf;

    logic [WIDTH:0]     w_a_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic               w_div_zero;
    logic               w_idle_like;
    logic [WIDTH-1:0]   w_dd_mag;
    logic [WIDTH-1:0]   w_dv_mag;
    logic               w_ovf_case;

    assign w_div_zero  = (divisor == '0);
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign w_dd_mag    = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dv_mag    = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_ovf_case  = (dividend == c_MIN_NEG) && (divisor == '1);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .a      (r_a),
        .q      (r_q),
        .m      (r_m),
        .a_next (w_a_nx),
        .q_next (w_q_nx)
    );

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    w_state_nx = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nx = ST_FIX;
                end
            end
            ST_FIX:  w_state_nx = ST_DONE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_sd        <= 1'b0;
            r_sv        <= 1'b0;
            r_ovf       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (w_idle_like && load) begin
                if (w_div_zero) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end else begin
                    r_q         <= w_dd_mag;
                    r_m         <= w_dv_mag;
                    r_a         <= '0;
                    r_sd        <= dividend[WIDTH-1];
                    r_sv        <= divisor[WIDTH-1];
                    r_ovf       <= w_ovf_case;
                    r_cnt       <= c_CNT_INIT;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b1;
                end
            end else if (r_state == ST_RUN) begin
                r_a   <= w_a_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt - c_CNT_ONE;
            end else if (r_state == ST_FIX) begin
                quotient  <= (r_sd ^ r_sv) ? -r_q : r_q;
                remainder <= r_sd ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
                overflow  <= r_ovf;
                busy      <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_restoring_divider
// Brief  : Scoreboard bench for seq_restoring_divider against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W = 6;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           edge_n;
    } exp_t;

    logic         clk_fast = 1'b0;
    logic         rst      = 1'b1;
    logic         load     = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   edge_cnt   = 0;
    int   busy_until = 0;
    logic prev_done  = 1'b0;
    logic prev_load  = 1'b0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .load        (load),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk_fast = ~clk_fast;

    always @(posedge clk_fast) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Signed division with SV integers truncates toward zero and keeps the dividend's sign.
    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv, input int e);
        exp_t x;
        int a;
        int b;
        a = $signed(dd);
        b = $signed(dv);
        x.dz = 1'b0;
        x.ov = 1'b0;
        if (b == 0) begin
            x.q      = '1;
            x.r      = dd;
            x.dz     = 1'b1;
            x.edge_n = e;
        end else begin
            x.ov     = (a == -(1 << (W - 1))) && (b == -1);
            x.q      = W'(a / b);
            x.r      = W'(a % b);
            x.edge_n = e + W + 1;
        end
        return x;
    endfunction

    task automatic do_load(input logic [W-1:0] dd, input logic [W-1:0] dv);
        int e;
        bit accepted;
        @(posedge clk_fast); #1;
        e        = edge_cnt + 1;
        accepted = (e > busy_until);
        dividend = dd;
        divisor  = dv;
        load     = 1'b1;
        if (accepted) begin
            sb.push_back(model(dd, dv, e));
            if (dv != '0) busy_until = e + W + 1;
        end
        @(posedge clk_fast); #1;
        load = 1'b0;
        if (accepted) begin
            chk("busy_after_load", int'(busy), (dv != '0) ? 1 : 0);
            chk("done_after_load", int'(done), (dv != '0) ? 0 : 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk_fast);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_q"},    int'(quotient),    0);
        chk({tag, "_r"},    int'(remainder),   0);
        chk({tag, "_busy"}, int'(busy),        0);
        chk({tag, "_done"}, int'(done),        0);
        chk({tag, "_dz"},   int'(div_by_zero), 0);
        chk({tag, "_ov"},   int'(overflow),    0);
    endtask

    // A new result is either a rising done, or done staying high across an accepted load.
    always @(negedge clk_fast) begin
        if (rst) begin
            prev_done = 1'b0;
            prev_load = 1'b0;
        end else begin
            if (done && (!prev_done || prev_load)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got result q=%0d at edge %0d, expected none", quotient, edge_cnt);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("quotient",    int'(quotient),    int'(x.q));
                    chk("remainder",   int'(remainder),   int'(x.r));
                    chk("div_by_zero", int'(div_by_zero), int'(x.dz));
                    chk("overflow",    int'(overflow),    int'(x.ov));
                    chk("busy_done",   int'(busy),        0);
                    chk("latency",     edge_cnt,          x.edge_n);
                end
            end
            prev_done = done;
            prev_load = load;
        end
    end

    initial begin
        logic [W-1:0] rdd;
        logic [W-1:0] rdv;
        int sel;
        repeat (3) @(posedge clk_fast);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        do_load(6'b000111, 6'b000011);
        wait_idle();
        do_load(6'b111001, 6'b000011);
        wait_idle();
        do_load(6'b000111, 6'b000000);
        wait_idle();
        do_load(6'b100000, 6'b111111);
        wait_idle();
        do_load(6'b011111, 6'b100000);
        wait_idle();
        do_load(6'd20, 6'd6);
        do_load(6'd1, 6'd1);
        wait_idle();
        do_load(6'b100000, 6'b000000);
        do_load(6'b100000, 6'b000011);
        wait_idle();

        do_load(6'd7, 6'd3);
        repeat (2) @(posedge clk_fast);
        #3;
        rst = 1'b1;
        #1;
        chk_zero_outputs("async_reset");
        sb.delete();
        busy_until = 0;
        @(posedge clk_fast);
        #2;
        rst = 1'b0;
        do_load(6'd6, 6'd2);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            rdd = W'($urandom);
            sel = $urandom_range(0, 19);
            if (sel == 0)      rdv = '0;
            else if (sel == 1) rdv = '1;
            else               rdv = W'($urandom);
            if (sel == 2) rdd = 6'b100000;
            do_load(rdd, rdv);
            repeat ($urandom_range(0, W + 3)) @(posedge clk_fast);
        end
        wait_idle();
        repeat (3) @(posedge clk_fast);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_restoring_divider
`default_nettype wire
